// File: rtl/runner_world_engine_if.sv
// Signal bundle between the frame-tick source / game FSM / renderer and the world engine.
// Handshake: frame_tick is a one-clock pulse with no back-pressure, consumed in the cycle it is high.
interface runner_world_engine_if;
    logic        frame_tick;
    logic        start;
    logic        jump;
    logic        collided;
    logic        reached_screen_end;
    logic        running;
    logic [10:0] scroll_offset;
    logic [5:0]  player_y;
    logic [1:0]  run_state;
    logic [1:0]  jump_state;

    modport master (
        output frame_tick, start, jump,
        input  collided, reached_screen_end, running, scroll_offset, player_y,
        input  run_state, jump_state
    );

    modport slave (
        input  frame_tick, start, jump,
        output collided, reached_screen_end, running, scroll_offset, player_y,
        output run_state, jump_state
    );
endinterface

// File: rtl/runner_world_engine.sv
// Scrolls the world, runs the jump arc and checks the player box against three fixed obstacles.
// Produces sticky collided / reached_screen_end levels for the game FSM.
module runner_world_engine #(
    parameter int unsigned WORLD_LEN   = 640,
    parameter int unsigned SCROLL_STEP = 2,
    parameter int unsigned PLAYER_X    = 40,
    parameter int unsigned PLAYER_W    = 16,
    parameter int unsigned JUMP_HEIGHT = 48,
    parameter int unsigned JUMP_STEP   = 4,
    parameter int unsigned OBST_W      = 8,
    parameter int unsigned OBST_H      = 16,
    parameter int unsigned OBST0_X     = 200,
    parameter int unsigned OBST1_X     = 380,
    parameter int unsigned OBST2_X     = 560
) (
    input  logic                  clock,
    input  logic                  reset,
    runner_world_engine_if.slave  bus_if
);
    typedef enum logic [1:0] {
        RUN_IDLE   = 2'd0,
        RUN_ACTIVE = 2'd1,
        RUN_DONE   = 2'd2
    } run_state_t;

    typedef enum logic [1:0] {
        JMP_GROUND = 2'd0,
        JMP_RISE   = 2'd1,
        JMP_FALL   = 2'd2
    } jump_state_t;

    localparam logic [11:0] WL12   = 12'(WORLD_LEN);
    localparam logic [11:0] STEP12 = 12'(SCROLL_STEP);
    localparam logic [11:0] PX12   = 12'(PLAYER_X);
    localparam logic [11:0] PW12   = 12'(PLAYER_W);
    localparam logic [11:0] OW12   = 12'(OBST_W);
    localparam logic [11:0] O0_12  = 12'(OBST0_X);
    localparam logic [11:0] O1_12  = 12'(OBST1_X);
    localparam logic [11:0] O2_12  = 12'(OBST2_X);
    localparam logic [5:0]  JH6    = 6'(JUMP_HEIGHT);
    localparam logic [5:0]  JS6    = 6'(JUMP_STEP);
    localparam logic [5:0]  OH6    = 6'(OBST_H);

    run_state_t  run_q, run_d;
    jump_state_t jump_q, jump_d;
    logic [10:0] scroll_q, scroll_d;
    logic [5:0]  y_q, y_d;
    logic        collided_q, collided_d;
    logic        end_q, end_d;
    logic        pending_q, pending_d;

    logic [11:0] player_lo, player_hi;
    logic [11:0] scroll_sum, scroll_sat;
    logic [2:0]  overlap;
    logic        hit, at_end;
    logic [5:0]  y_up, y_dn;
    logic        run_ends;

    // Geometry is evaluated on the registered (post-tick) scroll and height.
    always_comb begin
        player_lo  = {1'b0, scroll_q} + PX12;
        player_hi  = player_lo + PW12;
        overlap[0] = (player_lo < (O0_12 + OW12)) && (player_hi > O0_12);
        overlap[1] = (player_lo < (O1_12 + OW12)) && (player_hi > O1_12);
        overlap[2] = (player_lo < (O2_12 + OW12)) && (player_hi > O2_12);
        hit        = (|overlap) && (y_q < OH6);
        at_end     = ({1'b0, scroll_q} == WL12);
        scroll_sum = {1'b0, scroll_q} + STEP12;
        scroll_sat = (scroll_sum > WL12) ? WL12 : scroll_sum;
        y_up       = y_q + JS6;
        y_dn       = y_q - JS6;
    end

    always_comb begin
        run_d      = run_q;
        jump_d     = jump_q;
        scroll_d   = scroll_q;
        y_d        = y_q;
        collided_d = collided_q;
        end_d      = end_q;
        pending_d  = pending_q;
        run_ends   = 1'b0;

        case (run_q)
            RUN_IDLE, RUN_DONE: begin
                if (bus_if.start) begin
                    run_d      = RUN_ACTIVE;
                    jump_d     = JMP_GROUND;
                    scroll_d   = '0;
                    y_d        = '0;
                    collided_d = 1'b0;
                    end_d      = 1'b0;
                    pending_d  = 1'b0;
                end
            end

            RUN_ACTIVE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    if (hit) begin
                        collided_d = 1'b1;
                        run_d      = RUN_DONE;
                        run_ends   = 1'b1;
                    end else if (at_end) begin
                        end_d    = 1'b1;
                        run_d    = RUN_DONE;
                        run_ends = 1'b1;
                    end
                end

                // A tick landing on the check clock still advances the world unless that check ends the run.
                if (bus_if.frame_tick && !run_ends) begin
                    scroll_d  = 11'(scroll_sat);
                    pending_d = 1'b1;
                    case (jump_q)
                        JMP_GROUND: begin
                            if (bus_if.jump) begin
                                jump_d = JMP_RISE;
                                y_d    = JS6;
                            end
                        end
                        JMP_RISE: begin
                            y_d = y_up;
                            if (y_up == JH6) jump_d = JMP_FALL;
                        end
                        JMP_FALL: begin
                            y_d = y_dn;
                            if (y_dn == 6'd0) jump_d = JMP_GROUND;
                        end
                        default: jump_d = JMP_GROUND;
                    endcase
                end
            end

            default: run_d = RUN_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            run_q      <= RUN_IDLE;
            jump_q     <= JMP_GROUND;
            scroll_q   <= '0;
            y_q        <= '0;
            collided_q <= 1'b0;
            end_q      <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            run_q      <= run_d;
            jump_q     <= jump_d;
            scroll_q   <= scroll_d;
            y_q        <= y_d;
            collided_q <= collided_d;
            end_q      <= end_d;
            pending_q  <= pending_d;
        end
    end

    assign bus_if.collided           = collided_q;
    assign bus_if.reached_screen_end = end_q;
    assign bus_if.running            = (run_q == RUN_ACTIVE);
    assign bus_if.scroll_offset      = scroll_q;
    assign bus_if.player_y           = y_q;
    assign bus_if.run_state          = run_q;
    assign bus_if.jump_state         = jump_q;
endmodule

// File: tb/tb_runner_world_engine.sv
// Bench for runner_world_engine: three instances (default course, WORLD_LEN=64, WORLD_LEN=146) share stimulus.
// Expected values come from a hand-computed vector table plus a few hand-written sequences.
module tb_runner_world_engine;
    logic clock;
    logic reset;
    logic tick;
    logic start;
    logic jump;

    int total;
    int bad;

    runner_world_engine_if if_a ();
    runner_world_engine_if if_b ();
    runner_world_engine_if if_c ();

    assign if_a.frame_tick = tick;
    assign if_a.start      = start;
    assign if_a.jump       = jump;
    assign if_b.frame_tick = tick;
    assign if_b.start      = start;
    assign if_b.jump       = jump;
    assign if_c.frame_tick = tick;
    assign if_c.start      = start;
    assign if_c.jump       = jump;

    runner_world_engine dut_a (.clock(clock), .reset(reset), .bus_if(if_a));
    runner_world_engine #(.WORLD_LEN(64)) dut_b (.clock(clock), .reset(reset), .bus_if(if_b));
    runner_world_engine #(.WORLD_LEN(146)) dut_c (.clock(clock), .reset(reset), .bus_if(if_c));

    logic [10:0] scr [3];
    logic [5:0]  py  [3];
    logic        col [3];
    logic        fin [3];
    logic        run [3];
    logic [1:0]  rst_st [3];
    logic [1:0]  jmp_st [3];

    assign scr[0] = if_a.scroll_offset;
    assign scr[1] = if_b.scroll_offset;
    assign scr[2] = if_c.scroll_offset;
    assign py[0]  = if_a.player_y;
    assign py[1]  = if_b.player_y;
    assign py[2]  = if_c.player_y;
    assign col[0] = if_a.collided;
    assign col[1] = if_b.collided;
    assign col[2] = if_c.collided;
    assign fin[0] = if_a.reached_screen_end;
    assign fin[1] = if_b.reached_screen_end;
    assign fin[2] = if_c.reached_screen_end;
    assign run[0] = if_a.running;
    assign run[1] = if_b.running;
    assign run[2] = if_c.running;
    assign rst_st[0] = if_a.run_state;
    assign rst_st[1] = if_b.run_state;
    assign rst_st[2] = if_c.run_state;
    assign jmp_st[0] = if_a.jump_state;
    assign jmp_st[1] = if_b.jump_state;
    assign jmp_st[2] = if_c.jump_state;

    typedef struct {
        int scen;
        int dut;
        int tick;
        int scroll;
        int y;
        int coll;
        int fin;
        int run;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int d, input int s, input int y,
                             input int c, input int f, input int r);
        check($sformatf("%s dut%0d scroll", tag, d), 32'(scr[d]), 32'(s));
        check($sformatf("%s dut%0d player_y", tag, d), 32'(py[d]), 32'(y));
        check($sformatf("%s dut%0d collided", tag, d), 32'(col[d]), 32'(c));
        check($sformatf("%s dut%0d end", tag, d), 32'(fin[d]), 32'(f));
        check($sformatf("%s dut%0d running", tag, d), 32'(run[d]), 32'(r));
    endtask

    task automatic compare_table(input int scen, input int t);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].scen == scen && vecs[i].tick == t) begin
                check_all($sformatf("s%0d tick%0d", scen, t), vecs[i].dut, vecs[i].scroll,
                          vecs[i].y, vecs[i].coll, vecs[i].fin, vecs[i].run);
            end
        end
    endtask

    // Each tick is a one-clock pulse followed by one quiet clock for the check.
    task automatic run_ticks(input int scen, input int first, input int last, input int jump_tick);
        for (int t = first; t <= last; t++) begin
            jump = (t == jump_tick);
            tick = 1'b1;
            step();
            tick = 1'b0;
            jump = 1'b0;
            step();
            compare_table(scen, t);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        jump  = 1'b0;

        vecs[0]  = '{1, 0, 72, 144, 0, 0, 0, 1};
        vecs[1]  = '{1, 0, 73, 146, 0, 1, 0, 0};
        vecs[2]  = '{1, 0, 74, 146, 0, 1, 0, 0};
        vecs[3]  = '{1, 1, 31, 62, 0, 0, 0, 1};
        vecs[4]  = '{1, 1, 32, 64, 0, 0, 1, 0};
        vecs[5]  = '{1, 1, 33, 64, 0, 0, 1, 0};
        vecs[6]  = '{1, 2, 72, 144, 0, 0, 0, 1};
        vecs[7]  = '{1, 2, 73, 146, 0, 1, 0, 0};
        vecs[8]  = '{2, 0, 68, 136, 4, 0, 0, 1};
        vecs[9]  = '{2, 0, 79, 158, 48, 0, 0, 1};
        vecs[10] = '{2, 0, 91, 182, 0, 0, 0, 1};
        vecs[11] = '{2, 0, 99, 198, 0, 0, 0, 1};
        vecs[12] = '{2, 0, 162, 324, 0, 0, 0, 1};
        vecs[13] = '{2, 0, 163, 326, 0, 1, 0, 0};
        vecs[14] = '{2, 2, 73, 146, 24, 0, 1, 0};

        step();
        step();
        reset = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
            check_all("reset", d, 0, 0, 0, 0, 0);
            check($sformatf("reset dut%0d run_state", d), 32'(rst_st[d]), 32'd0);
            check($sformatf("reset dut%0d jump_state", d), 32'(jmp_st[d]), 32'd0);
        end

        // Ticks in IDLE must not move the world.
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        check_all("idle tick", 0, 0, 0, 0, 0, 0);

        do_start();
        for (int d = 0; d < 3; d++) check_all("start", d, 0, 0, 0, 0, 1);

        // Scenario 1: no jump; default course hits obstacle 0 on tick 73.
        run_ticks(1, 1, 72, 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_all("tick73 pre-check", 0, 146, 0, 0, 0, 1);
        step();
        compare_table(1, 73);
        run_ticks(1, 74, 74, 0);

        // Restart from DONE.
        do_start();
        check_all("restart", 0, 0, 0, 0, 0, 1);
        check_all("restart", 1, 0, 0, 0, 0, 1);
        check_all("restart", 2, 0, 0, 0, 0, 1);

        // Scenario 2: single jump over obstacle 0, then obstacle 1 hit.
        run_ticks(2, 1, 163, 68);

        // Scenario 3: reset mid-run at tick 40.
        do_start();
        run_ticks(3, 1, 39, 0);
        check_all("tick39", 0, 78, 0, 0, 0, 1);
        tick  = 1'b1;
        reset = 1'b0;
        step();
        tick  = 1'b0;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) check_all("midrun reset", d, 0, 0, 0, 0, 0);
        run_ticks(3, 1, 3, 0);
        check_all("post-reset ticks", 0, 0, 0, 0, 0, 0);
        do_start();
        check_all("start after reset", 0, 0, 0, 0, 0, 1);
        run_ticks(3, 1, 1, 0);
        check_all("first tick after start", 0, 2, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/runner_world_engine.md
# runner_world_engine

Gameplay datapath that produces the `collided` and `reached_screen_end` status inputs consumed by the game-state FSM. On each frame tick it scrolls the world, runs Snoopy's jump state machine, and checks the player box against a fixed three-obstacle course. Both status flags are sticky levels, so the game FSM always samples a stable value. The block sits between the frame-tick generator and the game FSM; the VGA renderer reads `scroll_offset` and `player_y`.

## Interface
- `WORLD_LEN`, 640: world length in pixels; the scroll saturates here.
- `SCROLL_STEP`, 2: pixels scrolled per frame tick.
- `PLAYER_X`, 40: fixed screen x of the player's left edge.
- `PLAYER_W`, 16: player width.
- `JUMP_HEIGHT`, 48: jump apex, must be a multiple of `JUMP_STEP`.
- `JUMP_STEP`, 4: vertical pixels moved per tick.
- `OBST_W`, 8 / `OBST_H`, 16: obstacle width and height.
- `OBST0_X`, 200 / `OBST1_X`, 380 / `OBST2_X`, 560: obstacle world x positions.
- `clock` input 1: system clock.
- `reset` input 1: reset, synchronous, active-low.
- `frame_tick` input 1: one-clock pulse per video frame.
- `start` input 1: level, the same `user_input` button that feeds the game FSM.
- `jump` input 1: level, the jump button.
- `collided` output 1: sticky, the player hit an obstacle.
- `reached_screen_end` output 1: sticky, the scroll reached `WORLD_LEN`.
- `running` output 1: high in RUN.
- `scroll_offset` output 11: world x of the screen's left edge.
- `player_y` output 6: player height above ground.

## Operation
- Run FSM:
  - IDLE: on `start`=1, enter RUN. Clear `scroll_offset`, `player_y`, both flags, the jump FSM and the pending-check bit.
  - RUN:
    - Each `frame_tick` sets `scroll_offset` = min(`scroll_offset`+`SCROLL_STEP`, `WORLD_LEN`), steps the jump FSM, and sets `check_pending`.
    - `start` is ignored in RUN.
  - DONE: hold all outputs. On `start`=1, restart exactly as from IDLE.
- Jump FSM (advances only on `frame_tick` in RUN):
  - GROUND: if `jump`=1, enter RISE and set `player_y` to `JUMP_STEP`.
  - RISE: add `JUMP_STEP` to `player_y`. When the new value equals `JUMP_HEIGHT`, enter FALL.
  - FALL: subtract `JUMP_STEP`. When the new value is 0, enter GROUND.
  - `jump` is ignored while airborne.
- Collision check (the clock after a tick, when `check_pending`=1):
  - Player world span is [`scroll_offset`+`PLAYER_X`, `scroll_offset`+`PLAYER_X`+`PLAYER_W`).
  - Obstacle i span is [`OBSTi_X`, `OBSTi_X`+`OBST_W`).
  - A hit is any span overlap with `player_y` < `OBST_H`.
  - All comparisons use 12-bit unsigned arithmetic; there are no negative terms.
- Check outcome:
  - On a hit: `collided` is set and the FSM enters DONE.
  - Otherwise, if `scroll_offset`==`WORLD_LEN`: `reached_screen_end` is set and the FSM enters DONE.
  - If both conditions are true, only `collided` is set.
  - `check_pending` clears on every check.
- A `frame_tick` arriving in the check clock is processed normally; the checks for the two ticks then occur back to back.

## Timing
- Reset (`reset`=0 at a clock edge) puts every output at 0, the run FSM in IDLE, the jump FSM in GROUND, and clears `check_pending`. Reset takes effect mid-run as well.
- `start` sampled at edge E: `running`=1 after E.
- `frame_tick` sampled at edge N: `scroll_offset` and `player_y` update after N. Flags and the DONE transition are registered at N+1. `running` drops after N+1.
- Flags change only at the check edge, so the game FSM sees either a clean level or nothing.
- Ticks arriving in IDLE or DONE are ignored.

## Test plan
- Collision with no jump:
  - Stimulus: reset, `start`, then ticks 1..73.
  - At tick 72, `scroll_offset`=144 and there is no hit.
  - At tick 73, `scroll_offset`=146 and `collided`=1 one clock later. `running`=0, `reached_screen_end`=0.
- Clean jump:
  - Stimulus: hold `jump` for tick 68 only.
  - `player_y`=4 at tick 68, 48 at tick 79, 0 at tick 91.
  - No collision through tick 99; `collided` rises at tick 163 (obstacle 1).
- Course end:
  - Stimulus: override `WORLD_LEN`=64 and run 32 ticks.
  - `scroll_offset`=64 and `reached_screen_end`=1 one clock after tick 32.
  - Tick 33 leaves `scroll_offset` at 64.
- Simultaneous hit and end:
  - Stimulus: `WORLD_LEN`=146.
  - At tick 73, only `collided`=1 and `reached_screen_end`=0.
- Reset mid-run:
  - Stimulus: apply `reset`=0 at tick 40.
  - All outputs are 0 the next clock; ticks are then ignored until `start`.
- Restart from DONE:
  - Stimulus: after the tick-73 collision, assert `start`.
  - Flags and `scroll_offset` clear and `running`=1 one clock later.
